// File: rtl/hex_share_arbiter_if.sv
// Requester/display bundle for hex_share_arbiter.
// HEX_OWNER exists only when HEX_SHOW_OWNER_EN is defined.
interface hex_share_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    localparam int unsigned OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]   REQ;
    logic [4*NUM_REQ-1:0] VAL;
    logic [NUM_REQ-1:0]   GNT;
    logic [OWN_W-1:0]     OWNER;
    logic                 BUSY;
    logic [6:0]           HEX;
`ifdef HEX_SHOW_OWNER_EN
    logic [6:0]           HEX_OWNER;

    modport master (output REQ, VAL, input GNT, OWNER, BUSY, HEX, HEX_OWNER);
    modport slave  (input REQ, VAL, output GNT, OWNER, BUSY, HEX, HEX_OWNER);
`else
    modport master (output REQ, VAL, input GNT, OWNER, BUSY, HEX);
    modport slave  (input REQ, VAL, output GNT, OWNER, BUSY, HEX);
`endif
endinterface

// File: rtl/hex_share_arbiter.sv
// Round-robin sharing of one 7-segment digit among NUM_REQ requesters with a minimum hold.
// Optional macro HEX_SHOW_OWNER_EN adds HEX_OWNER, the decoded owner index.
module hex_share_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned HOLD_CYCLES = 50000000,
    parameter int unsigned CNT_W       = 26
) (
    input  logic               CLOCK_50,
    input  logic               RESET,
    hex_share_arbiter_if.slave bus
);
    localparam int unsigned OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [6:0] BLANK = 7'h7F;

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    state_t             state, state_nx;
    logic [NUM_REQ-1:0] gnt, gnt_nx;
    logic [OWN_W-1:0]   owner, owner_nx;
    logic [OWN_W-1:0]   ptr, ptr_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic               busy, busy_nx;
    logic [6:0]         hex, hex_nx;
`ifdef HEX_SHOW_OWNER_EN
    logic [6:0]         hex_own, hex_own_nx;
`endif

    logic [OWN_W-1:0]   sel;
    logic               sel_vld;
    logic [3:0]         own_val;
    logic               req_own;
    logic               req_other;

    // Rotating priority scan starting at ptr; wraps naturally since NUM_REQ is a power of 2.
    always_comb begin
        logic [OWN_W-1:0] idx;
        sel     = '0;
        sel_vld = 1'b0;
        idx     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = ptr + OWN_W'(i);
            if (!sel_vld && bus.REQ[idx]) begin
                sel     = idx;
                sel_vld = 1'b1;
            end
        end
    end

    // Value nibble of the current owner; gnt is onehot(owner) throughout GRANT.
    always_comb begin
        own_val = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (OWN_W'(i) == owner) own_val = bus.VAL[4*i +: 4];
        end
        req_own   = |(bus.REQ & gnt);
        req_other = |(bus.REQ & ~gnt);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_nx   = state;
        gnt_nx     = gnt;
        owner_nx   = owner;
        ptr_nx     = ptr;
        cnt_nx     = cnt;
        busy_nx    = busy;
        hex_nx     = BLANK;
`ifdef HEX_SHOW_OWNER_EN
        hex_own_nx = BLANK;
`endif
        case (state)
            IDLE: begin
                gnt_nx  = '0;
                busy_nx = 1'b0;
                if (sel_vld) begin
                    state_nx = GRANT;
                    gnt_nx   = NUM_REQ'(1) << sel;
                    owner_nx = sel;
                    cnt_nx   = '0;
                    busy_nx  = 1'b1;
                end
            end
            GRANT: begin
                if (cnt != HOLD_LAST) cnt_nx = cnt + CNT_W'(1);
                // Voluntary drop wins over preemption; either way only one release happens.
                if (!req_own || (cnt == HOLD_LAST && req_other)) begin
                    state_nx = RELEASE;
                    gnt_nx   = '0;
                    busy_nx  = 1'b0;
                    ptr_nx   = owner + OWN_W'(1);
                end else begin
                    hex_nx     = seg_decode(own_val);
`ifdef HEX_SHOW_OWNER_EN
                    hex_own_nx = seg_decode(4'(owner));
`endif
                end
            end
            RELEASE: begin
                state_nx = IDLE;
                gnt_nx   = '0;
                busy_nx  = 1'b0;
            end
            default: begin
                state_nx = IDLE;
                gnt_nx   = '0;
                busy_nx  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state   <= IDLE;
            gnt     <= '0;
            owner   <= '0;
            ptr     <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            hex     <= BLANK;
`ifdef HEX_SHOW_OWNER_EN
            hex_own <= BLANK;
`endif
        end else begin
            state   <= state_nx;
            gnt     <= gnt_nx;
            owner   <= owner_nx;
            ptr     <= ptr_nx;
            cnt     <= cnt_nx;
            busy    <= busy_nx;
            hex     <= hex_nx;
`ifdef HEX_SHOW_OWNER_EN
            hex_own <= hex_own_nx;
`endif
        end
    end

    assign bus.GNT   = gnt;
    assign bus.OWNER = owner;
    assign bus.BUSY  = busy;
    assign bus.HEX   = hex;
`ifdef HEX_SHOW_OWNER_EN
    assign bus.HEX_OWNER = hex_own;
`endif

endmodule

// File: tb/tb_hex_share_arbiter.sv
// Bench for hex_share_arbiter: directed scenarios plus random traffic against a grant-level model.
module tb_hex_share_arbiter;
    localparam int N    = 4;
    localparam int HOLD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hex_share_arbiter_if #(.NUM_REQ(N)) bif ();

    hex_share_arbiter #(.NUM_REQ(N), .HOLD_CYCLES(HOLD), .CNT_W(3)) dut (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .bus      (bif.slave)
    );

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int checks = 0;
    int errors = 0;

    // Model: m_held = cycles already spent granted (-1 when no grant), m_rel = release cycle pending.
    int         m_own, m_ptr, m_held;
    bit         m_rel;
    logic [6:0] m_hex, m_hexo;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_own = 0; m_ptr = 0; m_held = -1; m_rel = 0;
        m_hex = 7'h7F; m_hexo = 7'h7F;
    endtask

    task automatic model_step();
        int others;
        if (rst) begin
            model_reset();
            return;
        end
        if (m_rel) begin
            m_rel = 0;
        end else if (m_held < 0) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (m_held < 0 && bif.REQ[idx]) begin
                    m_own  = idx;
                    m_held = 0;
                end
            end
        end else begin
            others = 0;
            for (int k = 0; k < N; k++) if (k != m_own && bif.REQ[k]) others = 1;
            if (!bif.REQ[m_own] || (m_held >= HOLD - 1 && others != 0)) begin
                m_rel  = 1;
                m_held = -1;
                m_ptr  = (m_own + 1) % N;
                m_hex  = 7'h7F;
                m_hexo = 7'h7F;
            end else begin
                m_held++;
                m_hex  = seg_tab[bif.VAL[4*m_own +: 4]];
                m_hexo = seg_tab[m_own];
            end
        end
    endtask

    task automatic check_all(input string ctx);
        logic [N-1:0] eg;
        eg = (m_held >= 0) ? (N'(1) << m_own) : '0;
        chk({ctx, ".gnt"},   32'(bif.GNT),   32'(eg));
        chk({ctx, ".owner"}, 32'(bif.OWNER), 32'(m_own));
        chk({ctx, ".busy"},  32'(bif.BUSY),  32'(m_held >= 0));
        chk({ctx, ".hex"},   32'(bif.HEX),   32'(m_hex));
`ifdef HEX_SHOW_OWNER_EN
        chk({ctx, ".hexo"},  32'(bif.HEX_OWNER), 32'(m_hexo));
`endif
    endtask

    task automatic tick(input string ctx);
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all(ctx);
    endtask

    // Assert reset between clock edges and check outputs before any edge arrives.
    task automatic reset_now(input string ctx);
        rst = 1'b1;
        #1;
        model_reset();
        check_all(ctx);
    endtask

    initial begin
        int         owners[$];
        logic [6:0] hexes[$];
        logic [N-1:0] prev_gnt;
        logic [6:0] prev_hex;
        int         width;

        model_reset();
        bif.REQ = '0;
        bif.VAL = '0;
        @(negedge clk);

        // Reset held with all requests high.
        bif.REQ = 4'b1111;
        reset_now("s1_rst");
        tick("s1_held");
        tick("s1_held");
        chk("s1_gnt_held", 32'(bif.GNT), 32'h0);

        // Sole requester 2 holds indefinitely.
        bif.REQ = 4'b0100;
        bif.VAL = 16'h0100;
        rst = 1'b0;
        tick("s2");
        chk("s2_gnt", 32'(bif.GNT), 32'b0100);
        chk("s2_owner", 32'(bif.OWNER), 32'd2);
        chk("s2_busy", 32'(bif.BUSY), 32'd1);
        tick("s2");
        chk("s2_hex", 32'(bif.HEX), 32'b1111001);
        for (int i = 0; i < 3 * HOLD; i++) tick("s2_hold");
        chk("s2_gnt_hold", 32'(bif.GNT), 32'b0100);

        // Fair rotation with all requests asserted.
        reset_now("s3_rst");
        bif.REQ = 4'b1111;
        bif.VAL = 16'h3210;
        tick("s3_rst");
        rst = 1'b0;
        prev_gnt = '0;
        prev_hex = 7'h7F;
        width = 0;
        for (int i = 0; i < 30; i++) begin
            tick("s3");
            if (prev_gnt == '0 && bif.GNT != '0) owners.push_back(int'(bif.OWNER));
            if (prev_hex == 7'h7F && bif.HEX != 7'h7F) hexes.push_back(bif.HEX);
            if (owners.size() == 1 && bif.GNT != '0) width++;
            prev_gnt = bif.GNT;
            prev_hex = bif.HEX;
        end
        chk("s3_ngrants", 32'(owners.size()), 32'd5);
        for (int i = 0; i < 5 && i < owners.size(); i++)
            chk($sformatf("s3_owner%0d", i), 32'(owners[i]), 32'(i % N));
        chk("s3_width", 32'(width), 32'(HOLD));
        for (int i = 0; i < 4 && i < hexes.size(); i++)
            chk($sformatf("s3_hex%0d", i), 32'(hexes[i]), 32'(seg_tab[i]));

        // Voluntary release before hold expiry hands over to requester 3.
        reset_now("s4_rst");
        bif.REQ = 4'b0010;
        tick("s4_rst");
        rst = 1'b0;
        tick("s4");
        chk("s4_gnt1", 32'(bif.GNT), 32'b0010);
        tick("s4");
        bif.REQ = 4'b1000;
        tick("s4");
        chk("s4_release_gnt", 32'(bif.GNT), 32'h0);
        chk("s4_release_owner", 32'(bif.OWNER), 32'd1);
        tick("s4");
        chk("s4_idle_gnt", 32'(bif.GNT), 32'h0);
        tick("s4");
        chk("s4_gnt3", 32'(bif.GNT), 32'b1000);

        // Value change propagates to HEX after exactly one clock.
        reset_now("s5_rst");
        bif.REQ = 4'b0001;
        bif.VAL = 16'h000A;
        tick("s5_rst");
        rst = 1'b0;
        tick("s5");
        tick("s5");
        chk("s5_hexA", 32'(bif.HEX), 32'b0001000);
        bif.VAL = 16'h000F;
        #1;
        chk("s5_hex_noedge", 32'(bif.HEX), 32'b0001000);
        tick("s5");
        chk("s5_hexF", 32'(bif.HEX), 32'b0001110);

        // Reset mid-grant, then arbitration restarts from index 0.
        reset_now("s6_rst");
        bif.REQ = 4'b0010;
        bif.VAL = 16'h0050;
        tick("s6_rst");
        rst = 1'b0;
        tick("s6");
        tick("s6");
        tick("s6");
`ifdef HEX_SHOW_OWNER_EN
        chk("s6_hexo1", 32'(bif.HEX_OWNER), 32'b1111001);
`endif
        chk("s6_hex5", 32'(bif.HEX), 32'b0010010);
        reset_now("s6_midrst");
        chk("s6_gnt_async", 32'(bif.GNT), 32'h0);
        chk("s6_hex_async", 32'(bif.HEX), 32'h7F);
        tick("s6_midrst");
        bif.REQ = 4'b1111;
        rst = 1'b0;
        tick("s6");
        chk("s6_restart", 32'(bif.GNT), 32'b0001);

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(5) == 0) bif.REQ[$urandom_range(N - 1)] ^= 1'b1;
            if ($urandom_range(3) == 0) bif.VAL = 16'($urandom);
            if ($urandom_range(149) == 0) begin
                reset_now("rnd_rst");
                tick("rnd_rst");
                rst = 1'b0;
            end else begin
                tick("rnd");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hex_share_arbiter.md
Name: hex_share_arbiter

Overview:
- Round-robin arbiter that shares one 7-segment HEX digit and one status LED among NUM_REQ requesters. Each requester presents a 4-bit value.
- The block grants the display to one requester at a time, decodes the granted value to active-low segments, and enforces a minimum hold time before rotating ownership.
- Sits between board-level lab logic (switch/key capture registers) and the HEX/LEDR pins.

Parameters:
- NUM_REQ, 4, number of requesters; power of 2, range 2..8.
- HOLD_CYCLES, 50000000, minimum grant duration in clocks (1 s at 50 MHz); must be >= 2.
- CNT_W, 26, hold counter width; must satisfy 2^CNT_W > HOLD_CYCLES.

Ports:
- CLOCK_50  in  1  system clock; all state on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- REQ  in  NUM_REQ  request per requester; level, held by requester while it wants the display.
- VAL  in  4*NUM_REQ  value per requester; requester i uses VAL[4i+3:4i].
- GNT  out  NUM_REQ  one-hot grant, registered.
- OWNER  out  log2(NUM_REQ)  index of current/last owner.
- BUSY  out  1  high while in GRANT.
- HEX  out  7  active-low segments {g,f,e,d,c,b,a}; 7'h7F = blank.

Behaviour:
- Reset (async, any state, including mid-grant): state=IDLE, GNT=0, OWNER=0, ptr=0, cnt=0, BUSY=0, HEX=7'h7F. Outputs change immediately on RESET assertion.
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - HEX=7'h7F, GNT=0, BUSY=0.
  - If any REQ bit is high, select the first set index scanning ptr, ptr+1, ... mod NUM_REQ.
  - Next clock: GRANT, GNT=onehot(sel), OWNER=sel, cnt=0, BUSY=1.
- GRANT:
  - HEX register loads decode(VAL[OWNER]) every clock, so HEX lags VAL by exactly 1 cycle. The first decoded value appears on the clock after GNT rises.
  - cnt increments by 1 per clock and saturates at HOLD_CYCLES-1.
  - If REQ[OWNER]=0: next state RELEASE, regardless of cnt.
  - Else if cnt==HOLD_CYCLES-1 and any other REQ bit is set: next state RELEASE (preemption).
  - Else stay in GRANT. A sole requester holds the display indefinitely.
- RELEASE (1 cycle):
  - GNT=0, BUSY=0, HEX=7'h7F, ptr=(OWNER+1) mod NUM_REQ; OWNER keeps its value.
  - Next state is IDLE. Minimum inter-grant gap is 2 cycles with GNT=0.
- Fairness: with all REQ high, owners rotate 0,1,2,...,NUM_REQ-1,0. Each grant lasts HOLD_CYCLES clocks with GNT high.
- Simultaneous events: an owner dropping REQ in the same cycle the hold expires is treated as release. Only one RELEASE occurs and ptr advances once.
- Segment decode, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- The REQ/VAL inputs are assumed synchronous to CLOCK_50; synchronizing them is the upstream block's responsibility.

Optional Feature:
- Macro HEX_SHOW_OWNER_EN.
- Defined: adds output HEX_OWNER (7 bits, active-low). In GRANT it shows decode(OWNER), registered with the same 1-cycle latency as HEX. It is 7'h7F in IDLE, in RELEASE and on reset.
- Undefined: port HEX_OWNER and its register do not exist; all other behaviour is identical.

Test Plan:
- Assert RESET with REQ=4'b1111 -> GNT=0, BUSY=0, HEX=7'h7F, OWNER=0 immediately and while held.
- Release reset, REQ=4'b0100, VAL[11:8]=4'h1 -> next clock GNT=4'b0100, OWNER=2, BUSY=1. The following clock HEX=7'b1111001. Grant holds for 3*HOLD_CYCLES with no rotation.
- HOLD_CYCLES=4, REQ=4'b1111, VAL=16'h3210 -> owners 0,1,2,3,0. Each GNT pulse is 4 cycles wide with a 2-cycle gap. HEX sequence is 1000000, 1111001, 0100100, 0110000.
- Owner 1 granted, REQ[1] dropped at cnt=1 with REQ[3]=1 -> RELEASE next clock, IDLE after, then GNT=4'b1000. Hold time is not enforced on voluntary release.
- While granted, change VAL of owner from 4'hA to 4'hF -> HEX goes from 0001000 to 0001110 exactly 1 clock later.
- RESET pulse mid-GRANT (cnt=2) -> GNT=0 and HEX=7'h7F without waiting for a clock. After release, arbitration restarts from ptr=0. With HEX_SHOW_OWNER_EN, HEX_OWNER=7'h7F at reset and shows 1111001 while owner 1 is granted.
